// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - PC/IR/AC datapath of the 8-bit accumulator CPU; define CPU_DATAPATH_CARRY_EN to add the carry flag
module cpu_datapath #(
  parameter int WORD_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch,
  input  logic                  load_ir,
  input  logic                  load_ac,
  input  logic                  load_pc,
  input  logic                  inc_pc,
  input  logic                  mem_wr,
  input  logic                  halt,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic                  zero,
  output logic                  halted
`ifdef CPU_DATAPATH_CARRY_EN
  ,
  output logic                  carry
`endif
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 3'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 3'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 3'd5;

  logic [ADDR_WIDTH-1:0] pc;
  logic [WORD_WIDTH-1:0] ir;
  logic [WORD_WIDTH-1:0] ac;
  logic [WORD_WIDTH-1:0] alu_res;
  logic [WORD_WIDTH-1:0] add_res;

`ifdef CPU_DATAPATH_CARRY_EN
  logic add_cout;
  assign {add_cout, add_res} = {1'b0, ac} + {1'b0, mem_rdata};
`else
  assign add_res = ac + mem_rdata;
`endif

  assign opcode    = ir[WORD_WIDTH-1:ADDR_WIDTH];
  assign mem_addr  = fetch ? pc : ir[ADDR_WIDTH-1:0];
  assign mem_wdata = ac;
  assign mem_we    = mem_wr & ~halted;
  // zero looks only at the stored AC, never at the ALU output
  assign zero      = (ac == '0);

  // ALU result selected by the opcode currently held in IR
  always_comb begin
    alu_res = ac;
    case (opcode)
      OP_ADD:  alu_res = add_res;
      OP_AND:  alu_res = ac & mem_rdata;
      OP_XOR:  alu_res = ac ^ mem_rdata;
      OP_LDA:  alu_res = mem_rdata;
      default: alu_res = ac;
    endcase
  end

  // Architectural registers; everything freezes once halted is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      ir     <= '0;
      ac     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (halt) begin
        halted <= 1'b1;
      end
      if (load_pc) begin
        pc <= ir[ADDR_WIDTH-1:0];
      end else if (inc_pc) begin
        pc <= pc + 1'b1;
      end
      if (load_ir) begin
        ir <= mem_rdata;
      end
      if (load_ac) begin
        ac <= alu_res;
      end
    end
  end

`ifdef CPU_DATAPATH_CARRY_EN
  // Carry follows each AC load: add carry-out for ADD, cleared otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (!halted && load_ac) begin
      carry <= (opcode == OP_ADD) ? add_cout : 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - self-checking bench for cpu_datapath
module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch, load_ir, load_ac, load_pc, inc_pc, mem_wr, halt;
  logic [7:0] mem_rdata;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [2:0] opcode;
  logic       zero;
  logic       halted;
`ifdef CPU_DATAPATH_CARRY_EN
  logic       carry;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference state, kept as plain integers
  int m_pc, m_ir, m_ac, m_halted, m_carry;

  cpu_datapath dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (fetch),
    .load_ir   (load_ir),
    .load_ac   (load_ac),
    .load_pc   (load_pc),
    .inc_pc    (inc_pc),
    .mem_wr    (mem_wr),
    .halt      (halt),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .opcode    (opcode),
    .zero      (zero),
`ifdef CPU_DATAPATH_CARRY_EN
    .carry     (carry),
`endif
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_ac = 0; m_halted = 0; m_carry = 0;
  endtask

  // one rising edge of the architectural machine, from the instruction-set rules
  task automatic model_clk();
    int op, alu, sum;
    if (m_halted != 0) return;
    op  = m_ir / 32;
    sum = m_ac + int'(mem_rdata);
    case (op)
      2:       alu = sum % 256;
      3:       alu = m_ac & int'(mem_rdata);
      4:       alu = m_ac ^ int'(mem_rdata);
      5:       alu = int'(mem_rdata);
      default: alu = m_ac;
    endcase
    if (halt) m_halted = 1;
    if (load_pc)     m_pc = m_ir % 32;
    else if (inc_pc) m_pc = (m_pc + 1) % 32;
    if (load_ac) begin
      m_carry = (op == 2 && sum > 255) ? 1 : 0;
      m_ac    = alu;
    end
    if (load_ir) m_ir = int'(mem_rdata);
  endtask

  task automatic clear_inputs();
    fetch = 0; load_ir = 0; load_ac = 0; load_pc = 0; inc_pc = 0; mem_wr = 0; halt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    mem_rdata = 8'h00;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_ir(input logic [7:0] v);
    clear_inputs();
    load_ir = 1; mem_rdata = v;
    tick();
    clear_inputs();
  endtask

  task automatic do_load_ac(input logic [7:0] v);
    clear_inputs();
    load_ac = 1; mem_rdata = v;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    fetch = 1; #1;
    n_checks++; if (mem_addr !== 5'd0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", mem_addr); end
    n_checks++; if (opcode !== 3'd0) begin n_fail++; $display("FAIL reset_opcode: got %0h want 0", opcode); end
    n_checks++; if (zero !== 1'b1 || mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_ac: zero=%b wdata=%0h want 1/00", zero, mem_wdata); end
    n_checks++; if (mem_we !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_we_halted: we=%b halted=%b want 0/0", mem_we, halted); end
    // load AC=0x3C and PC=7 via an LDA 7 instruction, then reset mid-cycle
    set_ir(8'hA7);
    load_ac = 1; load_pc = 1; mem_rdata = 8'h3C;
    tick();
    clear_inputs();
    fetch = 1; #1;
    n_checks++; if (mem_wdata !== 8'h3C || mem_addr !== 5'd7) begin n_fail++; $display("FAIL preload: ac=%0h pc=%0h want 3c/7", mem_wdata, mem_addr); end
    @(posedge clk); #2;
    rst_n = 1'b0; model_reset(); #1;
    n_checks++; if (mem_wdata !== 8'h00 || zero !== 1'b1) begin n_fail++; $display("FAIL async_reset_ac: ac=%0h zero=%b want 00/1", mem_wdata, zero); end
    n_checks++; if (mem_addr !== 5'd0 || opcode !== 3'd0 || halted !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL async_reset_state: pc=%0h op=%0h halted=%b we=%b want 0/0/0/0", mem_addr, opcode, halted, mem_we); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_fetch_decode();
    do_reset();
    repeat (4) begin inc_pc = 1; tick(); end
    clear_inputs();
    fetch = 1; load_ir = 1; mem_rdata = 8'h4A; #1;
    n_checks++; if (mem_addr !== 5'd4) begin n_fail++; $display("FAIL fetch_addr: got %0h want 4", mem_addr); end
    tick();
    n_checks++; if (opcode !== 3'd2) begin n_fail++; $display("FAIL decode_opcode: got %0h want 2", opcode); end
    clear_inputs(); #1;
    n_checks++; if (mem_addr !== 5'h0A) begin n_fail++; $display("FAIL operand_addr: got %0h want 0a", mem_addr); end
  endtask

  task automatic test_alu();
    do_reset();
    set_ir(8'hA0); do_load_ac(8'hF0);
    set_ir(8'h40); do_load_ac(8'h20);
    n_checks++; if (mem_wdata !== 8'h10 || zero !== 1'b0) begin n_fail++; $display("FAIL alu_add: ac=%0h zero=%b want 10/0", mem_wdata, zero); end
`ifdef CPU_DATAPATH_CARRY_EN
    n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL alu_add_carry: got %b want 1", carry); end
`endif
    set_ir(8'h60); do_load_ac(8'h0F);
    n_checks++; if (mem_wdata !== 8'h00 || zero !== 1'b1) begin n_fail++; $display("FAIL alu_and: ac=%0h zero=%b want 00/1", mem_wdata, zero); end
`ifdef CPU_DATAPATH_CARRY_EN
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL alu_and_carry: got %b want 0", carry); end
`endif
    set_ir(8'h80); do_load_ac(8'hFF);
    n_checks++; if (mem_wdata !== 8'hFF) begin n_fail++; $display("FAIL alu_xor: ac=%0h want ff", mem_wdata); end
    set_ir(8'hA0); do_load_ac(8'h55);
    n_checks++; if (mem_wdata !== 8'h55) begin n_fail++; $display("FAIL alu_lda: ac=%0h want 55", mem_wdata); end
    // load_ir and load_ac on one edge: ADD uses the old IR
    set_ir(8'h40);
    load_ir = 1; load_ac = 1; mem_rdata = 8'h0B;
    tick();
    clear_inputs(); #1;
    n_checks++; if (mem_wdata !== 8'h60 || opcode !== 3'd0 || mem_addr !== 5'h0B) begin n_fail++; $display("FAIL simultaneous: ac=%0h op=%0h addr=%0h want 60/0/0b", mem_wdata, opcode, mem_addr); end
  endtask

  task automatic test_pc_control();
    do_reset();
    set_ir(8'hFF);
    load_pc = 1; tick(); clear_inputs();
    fetch = 1; #1;
    n_checks++; if (mem_addr !== 5'd31) begin n_fail++; $display("FAIL jmp_31: got %0h want 1f", mem_addr); end
    inc_pc = 1; tick(); inc_pc = 0; #1;
    n_checks++; if (mem_addr !== 5'd0) begin n_fail++; $display("FAIL pc_wrap: got %0h want 0", mem_addr); end
    set_ir(8'hF3);
    load_pc = 1; inc_pc = 1; tick(); clear_inputs();
    fetch = 1; #1;
    n_checks++; if (mem_addr !== 5'h13) begin n_fail++; $display("FAIL load_pc_priority: got %0h want 13", mem_addr); end
  endtask

  task automatic test_store();
    do_reset();
    set_ir(8'hA0); do_load_ac(8'h77);
    set_ir(8'hC9);
    fetch = 0; mem_wr = 1; #1;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd9 || mem_wdata !== 8'h77) begin n_fail++; $display("FAIL store: we=%b addr=%0h wdata=%0h want 1/9/77", mem_we, mem_addr, mem_wdata); end
    halt = 1; tick(); halt = 0; #1;
    n_checks++; if (mem_we !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL store_after_halt: we=%b halted=%b want 0/1", mem_we, halted); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (5) begin inc_pc = 1; tick(); end
    halt = 1; inc_pc = 1; tick(); clear_inputs();
    fetch = 1; #1;
    n_checks++; if (mem_addr !== 5'd6 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_edge: pc=%0h halted=%b want 6/1", mem_addr, halted); end
    load_ir = 1; load_ac = 1; inc_pc = 1; load_pc = 1; mem_wr = 1; mem_rdata = 8'hFF;
    repeat (3) tick();
    fetch = 1; #1;
    n_checks++; if (mem_addr !== 5'd6 || opcode !== 3'd0 || mem_wdata !== 8'h00 || mem_we !== 1'b0) begin n_fail++; $display("FAIL halt_frozen: pc=%0h op=%0h ac=%0h we=%b want 6/0/00/0", mem_addr, opcode, mem_wdata, mem_we); end
    do_reset(); #1;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b want 0", halted); end
  endtask

  task automatic test_random();
    int exp_addr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      fetch     = 1'($urandom);
      load_ir   = 1'($urandom);
      load_ac   = 1'($urandom);
      load_pc   = ($urandom_range(0, 3) == 0);
      inc_pc    = 1'($urandom);
      mem_wr    = 1'($urandom);
      halt      = ($urandom_range(0, 79) == 0);
      mem_rdata = 8'($urandom);
      tick();
      #1;
      exp_addr = fetch ? m_pc : (m_ir % 32);
      n_checks++; if (int'(mem_addr) != exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %0h want %0h", i, mem_addr, exp_addr); end
      n_checks++; if (int'(opcode) != m_ir / 32) begin n_fail++; $display("FAIL rnd_opcode[%0d]: got %0h want %0h", i, opcode, m_ir / 32); end
      n_checks++; if (int'(mem_wdata) != m_ac || zero !== (m_ac == 0)) begin n_fail++; $display("FAIL rnd_ac[%0d]: ac=%0h zero=%b want %0h", i, mem_wdata, zero, m_ac); end
      n_checks++; if (halted !== (m_halted != 0) || mem_we !== (mem_wr && m_halted == 0)) begin n_fail++; $display("FAIL rnd_halt_we[%0d]: halted=%b we=%b want %0d", i, halted, mem_we, m_halted); end
`ifdef CPU_DATAPATH_CARRY_EN
      n_checks++; if (int'(carry) != m_carry) begin n_fail++; $display("FAIL rnd_carry[%0d]: got %b want %0d", i, carry, m_carry); end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    mem_rdata = 8'h00;
    model_reset();
    test_reset();
    test_fetch_decode();
    test_alu();
    test_pc_control();
    test_store();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath stage directly downstream of fsm_sequence_control in the 8-bit accumulator CPU.
- Consumes the controller strobes (load_ir, load_ac, load_pc, inc_pc, mem_wr, halt).
- Holds the PC, IR and AC, computes the ALU result, and drives the memory address, write data and write strobe.
- Returns opcode and zero to the controller, closing the fetch/execute loop.

Parameters:
- WORD_WIDTH, 8, width of data word, IR, AC and ALU; must equal OPCODE_WIDTH + ADDR_WIDTH.
- ADDR_WIDTH, 5, width of memory address and PC.
- OPCODE_WIDTH, 3, fixed at 3; the top OPCODE_WIDTH bits of IR form the opcode.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- fetch, input, 1, 1 selects PC as mem_addr (instruction phases); 0 selects the IR operand address.
- load_ir, input, 1, capture mem_rdata into IR.
- load_ac, input, 1, capture ALU result into AC.
- load_pc, input, 1, load PC from the IR address field.
- inc_pc, input, 1, increment PC.
- mem_wr, input, 1, store request from the controller.
- halt, input, 1, halt request from the controller.
- mem_rdata, input, WORD_WIDTH, memory read data.
- mem_addr, output, ADDR_WIDTH, memory address.
- mem_wdata, output, WORD_WIDTH, memory write data; always equal to AC.
- mem_we, output, 1, memory write enable.
- opcode, output, 3, opcodes_t; equal to IR[WORD_WIDTH-1:ADDR_WIDTH].
- zero, output, 1, 1 when AC == 0.
- halted, output, 1, sticky halted status.

Behaviour:
- Reset is async active-low on rst_n; clock is clk.
- Reset values: PC=0, IR=0 (opcode HLT), AC=0, halted=0. Resulting outputs: zero=1, mem_we=0, mem_wdata=0, mem_addr=0.
- Opcode encoding (typedefs::opcodes_t): HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- The IR address field is IR[ADDR_WIDTH-1:0].
- All register updates are blocked while halted=1. halted sets on the first rising edge with halt=1 and clears only on reset.
- The edge on which halt=1 is sampled still performs that cycle's other updates (e.g. a concurrent inc_pc).
- PC update, load_pc has priority:
  - load_pc=1: PC <= IR address field.
  - else inc_pc=1: PC <= PC+1, wrapping modulo 2^ADDR_WIDTH (31 -> 0).
  - else hold.
- IR: load_ir=1 -> IR <= mem_rdata; else hold.
- ALU (combinational, WORD_WIDTH result, keyed on opcode):
  - ADD: AC+mem_rdata, truncated modulo 2^WORD_WIDTH.
  - AND: AC&mem_rdata.
  - XOR: AC^mem_rdata.
  - LDA: mem_rdata.
  - HLT, SKZ, STO, JMP: AC (pass-through).
- AC: load_ac=1 -> AC <= ALU result; else hold.
- zero is combinational from the AC register only. It never reflects the ALU result before it is loaded.
- mem_addr = fetch ? PC : IR address field (combinational).
- mem_we = mem_wr & ~halted (combinational). No write is issued after halt.
- Latency: every register output is visible one cycle after its strobe. Loading IR updates opcode in the same cycle that IR updates.
- Simultaneous strobes: load_ir, load_ac and PC updates are independent and may all fire on one edge. load_ac uses the opcode from the pre-edge IR.
- Reset mid-instruction: all state returns to reset values immediately, without waiting for a clock.

Optional Feature:
- Macro: CPU_DATAPATH_CARRY_EN.
- Defined:
  - Adds output port carry (1 bit) and a carry register, reset 0.
  - On load_ac with opcode ADD, carry <= carry-out of the WORD_WIDTH-bit add.
  - On load_ac with any other opcode, carry <= 0.
  - Otherwise carry holds; it is also frozen while halted.
- Undefined: no carry port and no carry logic. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle after loading AC=0x3C, PC=7 -> immediately AC=0, PC=0, IR=0, zero=1, halted=0, mem_we=0.
- Fetch/decode: fetch=1, PC=4, mem_rdata=0x4A, load_ir=1 -> mem_addr=4; next cycle opcode=ADD(2), IR address=0x0A. With fetch=0, mem_addr=0x0A.
- ALU ops:
  - AC=0xF0, opcode ADD, mem_rdata=0x20, load_ac -> AC=0x10, zero=0 (carry=1 with CPU_DATAPATH_CARRY_EN).
  - AND 0x0F -> AC=0x00, zero=1.
  - XOR 0xFF from AC=0x00 -> AC=0xFF.
  - LDA 0x55 -> AC=0x55.
- PC control:
  - PC=31, inc_pc -> PC=0.
  - IR=0xF3 (JMP 0x13), load_pc and inc_pc on the same edge -> PC=0x13.
- Store: AC=0x77, IR=0xC9 (STO 9), fetch=0, mem_wr=1 -> mem_we=1, mem_addr=9, mem_wdata=0x77. After halted=1, mem_wr=1 -> mem_we=0.
- Halt: PC=5, halt=1 with inc_pc=1 -> PC=6, halted=1. Subsequent load_ir/load_ac/inc_pc have no effect until rst_n=0.
